// File: rtl/rpn_pkg.sv
// rpn_pkg: opcode constants, FSM state encoding and flag indices shared by the RPN core.
package rpn_pkg;
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   localparam logic [3:0] OP_DUP  = 4'd6;
   localparam logic [3:0] OP_SWAP = 4'd7;
   localparam logic [3:0] OP_DROP = 4'd8;
   localparam logic [3:0] OP_MUL  = 4'd9;

   typedef enum logic [1:0] {OCIOSO, EXEC, MULT} estado_t;

   localparam int FLAG_ZERO     = 0;
   localparam int FLAG_CARRY    = 1;
   localparam int FLAG_OVERFLOW = 2;
   localparam int FLAG_ERRO     = 3;

   function automatic logic eh_binaria(input logic [3:0] op);
      return op <= OP_XOR || op == OP_MUL;
   endfunction
endpackage

// File: rtl/ula_rpn_param.sv
// ula_rpn_param: combinational ALU for the RPN core; A is the top entry, B the one below.
module ula_rpn_param
   import rpn_pkg::*;
#(
   parameter int LARGURA = 8
) (
   input  logic [LARGURA-1:0] a,
   input  logic [LARGURA-1:0] b,
   input  logic [3:0]         op,
   output logic [LARGURA-1:0] resultado,
   output logic               zero,
   output logic               carry,
   output logic               overflow
);
   logic [LARGURA:0] soma, dif;

   assign soma = {1'b0, b} + {1'b0, a};
   assign dif  = {1'b0, b} - {1'b0, a};

   always_comb begin
      resultado = '0;
      carry     = 1'b0;
      overflow  = 1'b0;
      case (op)
         OP_ADD: begin
            resultado = soma[LARGURA-1:0];
            carry     = soma[LARGURA];
            overflow  = (a[LARGURA-1] == b[LARGURA-1]) && (soma[LARGURA-1] != b[LARGURA-1]);
         end
         OP_SUB: begin
            resultado = dif[LARGURA-1:0];
            carry     = dif[LARGURA];
            overflow  = (a[LARGURA-1] != b[LARGURA-1]) && (dif[LARGURA-1] != b[LARGURA-1]);
         end
         OP_AND:  resultado = b & a;
         OP_OR:   resultado = b | a;
         OP_XOR:  resultado = b ^ a;
         OP_NOT:  resultado = ~a;
         default: ;
      endcase
   end

   assign zero = resultado == '0;
endmodule

// File: rtl/nucleo_rpn_parametrizado.sv
// nucleo_rpn_parametrizado: parametrised RPN stack/ALU core with valid/ready command input.
// Define RPN_MULTIPLICADOR_EN to enable the iterative shift-add multiplier (opcode 9).
module nucleo_rpn_parametrizado
   import rpn_pkg::*;
#(
   parameter  int LARGURA      = 8,
   parameter  int PROFUNDIDADE = 4,
   localparam int LARG_CONT    = $clog2(PROFUNDIDADE + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_eh_op,
   input  logic [LARGURA-1:0]   in_dado,
   input  logic [3:0]           in_op,
   output logic [LARGURA-1:0]   topo_a,
   output logic [LARGURA-1:0]   topo_b,
   output logic [LARGURA-1:0]   resultado,
   output logic                 res_valido,
   output logic [LARG_CONT-1:0] ocupacao,
   output logic                 pilha_vazia,
   output logic                 pilha_cheia,
   output logic                 zero,
   output logic                 overflow,
   output logic                 carry,
   output logic                 erro
);
   estado_t estado, prox;
   logic [3:0] op_r;
   logic err_r;
   logic [3:0] flags;
   logic [LARG_CONT-1:0] ocup;
   // Entry 0 is the top; entries beyond ocup are kept at zero so topo_a/topo_b read 0 when absent.
   logic [LARGURA-1:0] pilha [PROFUNDIDADE];
   logic [LARGURA-1:0] pilha_nxt [PROFUNDIDADE];
   logic aceita, cheia, tem1, tem2, op_erro, vai_mult, mult_fim;
   logic exec_ok, push_ok, dup_ok, binaria, eh_ula, encolhe;
   logic [LARGURA-1:0] r_ula, r_fin;
   logic z_ula, c_ula, v_ula, z_fin, v_fin;

   assign aceita  = in_valid && in_ready;
   assign cheia   = ocup == LARG_CONT'(PROFUNDIDADE);
   assign tem1    = ocup != '0;
   assign tem2    = ocup >= LARG_CONT'(2);
   assign exec_ok = estado == EXEC && !err_r;
   assign push_ok = aceita && !in_eh_op && !cheia;
   assign binaria = eh_binaria(op_r);
   assign eh_ula  = binaria || op_r == OP_NOT;
   assign dup_ok  = exec_ok && op_r == OP_DUP;
   assign encolhe = exec_ok && (binaria || op_r == OP_DROP);

   always_comb begin
      case (in_op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SWAP: op_erro = !tem2;
         OP_NOT, OP_DROP: op_erro = !tem1;
         OP_DUP:          op_erro = !tem1 || cheia;
`ifdef RPN_MULTIPLICADOR_EN
         OP_MUL:          op_erro = !tem2;
`endif
         default:         op_erro = 1'b1;
      endcase
   end

   ula_rpn_param #(.LARGURA(LARGURA)) u_ula (
      .a(pilha[0]),
      .b(pilha[1]),
      .op(op_r),
      .resultado(r_ula),
      .zero(z_ula),
      .carry(c_ula),
      .overflow(v_ula)
   );

`ifdef RPN_MULTIPLICADOR_EN
   localparam int CW = $clog2(LARGURA);
   logic [2*LARGURA-1:0] prod, mcand;
   logic [LARGURA-1:0] mplier;
   logic [CW-1:0] cnt;

   assign vai_mult = in_op == OP_MUL && !op_erro;
   assign mult_fim = cnt == CW'(LARGURA - 1);
   assign r_fin    = op_r == OP_MUL ? prod[LARGURA-1:0] : r_ula;
   assign z_fin    = op_r == OP_MUL ? prod[LARGURA-1:0] == '0 : z_ula;
   assign v_fin    = op_r == OP_MUL ? |prod[2*LARGURA-1:LARGURA] : v_ula;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod   <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (aceita && in_eh_op) begin
         prod   <= '0;
         mcand  <= {{LARGURA{1'b0}}, pilha[0]};
         mplier <= pilha[1];
         cnt    <= '0;
      end else if (estado == MULT) begin
         prod   <= prod + (mplier[0] ? mcand : '0);
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
      end
   end
`else
   assign vai_mult = 1'b0;
   assign mult_fim = 1'b1;
   assign r_fin    = r_ula;
   assign z_fin    = z_ula;
   assign v_fin    = v_ula;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) estado <= OCIOSO;
      else estado <= prox;
   end

   always_comb begin
      prox = estado;
      case (estado)
         OCIOSO:  if (aceita && in_eh_op) prox = vai_mult ? MULT : EXEC;
         MULT:    prox = mult_fim ? EXEC : MULT;
         default: prox = OCIOSO;
      endcase
   end

   always_comb in_ready = estado == OCIOSO;

   always_comb begin
      pilha_nxt = pilha;
      if (push_ok || dup_ok) begin
         pilha_nxt[0] = push_ok ? in_dado : pilha[0];
         for (int i = 1; i < PROFUNDIDADE; i++) pilha_nxt[i] = pilha[i-1];
      end else if (exec_ok) begin
         if (encolhe) begin
            for (int i = 0; i < PROFUNDIDADE - 1; i++) pilha_nxt[i] = pilha[i+1];
            pilha_nxt[PROFUNDIDADE-1] = '0;
         end
         if (eh_ula) pilha_nxt[0] = r_fin;
         if (op_r == OP_SWAP) begin
            pilha_nxt[0] = pilha[1];
            pilha_nxt[1] = pilha[0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pilha      <= '{default: '0};
         ocup       <= '0;
         flags      <= '0;
         resultado  <= '0;
         res_valido <= 1'b0;
         op_r       <= '0;
         err_r      <= 1'b0;
      end else begin
         pilha      <= pilha_nxt;
         res_valido <= exec_ok && eh_ula;
         if (aceita && in_eh_op) begin
            op_r  <= in_op;
            err_r <= op_erro;
         end
         if (aceita && !in_eh_op) flags[FLAG_ERRO] <= cheia;
         if (estado == EXEC) flags[FLAG_ERRO] <= err_r;
         if (exec_ok && eh_ula) begin
            resultado            <= r_fin;
            flags[FLAG_ZERO]     <= z_fin;
            flags[FLAG_CARRY]    <= c_ula;
            flags[FLAG_OVERFLOW] <= v_fin;
         end
         if (push_ok || dup_ok) ocup <= ocup + LARG_CONT'(1);
         else if (encolhe) ocup <= ocup - LARG_CONT'(1);
      end
   end

   assign topo_a      = pilha[0];
   assign topo_b      = pilha[1];
   assign ocupacao    = ocup;
   assign pilha_vazia = ocup == '0;
   assign pilha_cheia = cheia;
   assign zero        = flags[FLAG_ZERO];
   assign carry       = flags[FLAG_CARRY];
   assign overflow    = flags[FLAG_OVERFLOW];
   assign erro        = flags[FLAG_ERRO];
endmodule

// File: tb/tb_nucleo_rpn_parametrizado.sv
// tb_nucleo_rpn_parametrizado: directed self-checking bench for the RPN core (LARGURA=8, PROFUNDIDADE=4).
module tb_nucleo_rpn_parametrizado;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic in_eh_op = 1'b0;
   logic [7:0] in_dado = '0;
   logic [3:0] in_op = '0;
   logic in_ready, res_valido, pilha_vazia, pilha_cheia, zero, overflow, carry, erro;
   logic [7:0] topo_a, topo_b, resultado;
   logic [2:0] ocupacao;
   int checks = 0;
   int errors = 0;

   nucleo_rpn_parametrizado #(.LARGURA(8), .PROFUNDIDADE(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_eh_op(in_eh_op), .in_dado(in_dado), .in_op(in_op),
      .topo_a(topo_a), .topo_b(topo_b), .resultado(resultado), .res_valido(res_valido),
      .ocupacao(ocupacao), .pilha_vazia(pilha_vazia), .pilha_cheia(pilha_cheia),
      .zero(zero), .overflow(overflow), .carry(carry), .erro(erro)
   );

   always #5 clk = ~clk;

   task automatic reset_dut();
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic enviar(input logic eh_op, input logic [3:0] op, input logic [7:0] d);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout in_ready=%b required 1", in_ready);
      end
      in_valid = 1'b1;
      in_eh_op = eh_op;
      in_op = op;
      in_dado = d;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      enviar(1'b0, 4'd0, d);
   endtask

   task automatic executar(input logic [3:0] op, output int ciclos, output logic pulso);
      enviar(1'b1, op, 8'h00);
      ciclos = 1;
      while (!in_ready && ciclos < 100) begin
         @(negedge clk);
         ciclos++;
      end
      pulso = res_valido;
   endtask

   task automatic test_reset();
      reset_dut();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (ocupacao !== 3'd0 || pilha_vazia !== 1'b1 || pilha_cheia !== 1'b0) begin errors++; $display("FAIL reset_ocupacao got %0d/%b/%b exp 0/1/0", ocupacao, pilha_vazia, pilha_cheia); end
      checks++; if ({topo_a, topo_b, resultado} !== 24'h0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", topo_a, topo_b, resultado); end
      checks++; if ({zero, overflow, carry, erro, res_valido} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {zero, overflow, carry, erro, res_valido}); end
   endtask

   task automatic test_add();
      reset_dut();
      push(8'h05);
      push(8'h03);
      enviar(1'b1, 4'd0, 8'h00);
      checks++; if (res_valido !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL add_exec_cycle got rv=%b rdy=%b exp 0/0", res_valido, in_ready); end
      @(negedge clk);
      checks++; if (res_valido !== 1'b1) begin errors++; $display("FAIL add_res_valido got %b exp 1", res_valido); end
      checks++; if (resultado !== 8'h08 || topo_a !== 8'h08 || ocupacao !== 3'd1) begin errors++; $display("FAIL add_result got %h/%h/%0d exp 08/08/1", resultado, topo_a, ocupacao); end
      checks++; if (zero !== 1'b0 || carry !== 1'b0 || erro !== 1'b0) begin errors++; $display("FAIL add_flags got z%b c%b e%b exp 000", zero, carry, erro); end
      @(negedge clk);
      checks++; if (res_valido !== 1'b0) begin errors++; $display("FAIL add_pulse_width got %b exp 0", res_valido); end
   endtask

   task automatic test_overflow();
      int c;
      logic p;
      reset_dut();
      push(8'h7F);
      push(8'h01);
      executar(4'd0, c, p);
      checks++; if (resultado !== 8'h80 || overflow !== 1'b1 || carry !== 1'b0) begin errors++; $display("FAIL ovf_7f_01 got %h v%b c%b exp 80 v1 c0", resultado, overflow, carry); end
      push(8'hFF);
      executar(4'd0, c, p);
      checks++; if (resultado !== 8'h7F || carry !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_80_ff got %h c%b v%b exp 7f c1 v1", resultado, carry, overflow); end
      reset_dut();
      push(8'h01);
      push(8'hFF);
      executar(4'd0, c, p);
      checks++; if (resultado !== 8'h00 || zero !== 1'b1 || carry !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL add_wrap got %h z%b c%b v%b exp 00 z1 c1 v0", resultado, zero, carry, overflow); end
   endtask

   task automatic test_sub_logic();
      int c;
      logic p;
      reset_dut();
      push(8'h03);
      push(8'h05);
      executar(4'd1, c, p);
      checks++; if (resultado !== 8'hFE || carry !== 1'b1 || overflow !== 1'b0 || p !== 1'b1) begin errors++; $display("FAIL sub got %h c%b v%b p%b exp fe c1 v0 p1", resultado, carry, overflow, p); end
      push(8'h3C);
      executar(4'd4, c, p);
      checks++; if (resultado !== 8'hC2 || carry !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL xor got %h c%b v%b exp c2 c0 v0", resultado, carry, overflow); end
      executar(4'd5, c, p);
      checks++; if (resultado !== 8'h3D || ocupacao !== 3'd1 || p !== 1'b1) begin errors++; $display("FAIL not got %h occ%0d p%b exp 3d 1 1", resultado, ocupacao, p); end
      push(8'h0F);
      executar(4'd2, c, p);
      checks++; if (resultado !== 8'h0D) begin errors++; $display("FAIL and got %h exp 0d", resultado); end
      push(8'h40);
      executar(4'd3, c, p);
      checks++; if (resultado !== 8'h4D || topo_a !== 8'h4D || ocupacao !== 3'd1) begin errors++; $display("FAIL or got %h/%h/%0d exp 4d/4d/1", resultado, topo_a, ocupacao); end
   endtask

   task automatic test_full();
      reset_dut();
      for (int i = 1; i <= 4; i++) push(8'(i));
      push(8'h09);
      checks++; if (erro !== 1'b1 || pilha_cheia !== 1'b1 || ocupacao !== 3'd4) begin errors++; $display("FAIL full_push got e%b f%b occ%0d exp 1 1 4", erro, pilha_cheia, ocupacao); end
      checks++; if (topo_a !== 8'h04 || topo_b !== 8'h03 || zero !== 1'b0) begin errors++; $display("FAIL full_top got %h %h z%b exp 04 03 z0", topo_a, topo_b, zero); end
   endtask

   task automatic test_errors();
      int c;
      logic p;
      reset_dut();
      executar(4'd0, c, p);
      checks++; if (erro !== 1'b1 || ocupacao !== 3'd0 || p !== 1'b0 || c !== 2) begin errors++; $display("FAIL underflow_add got e%b occ%0d p%b c%0d exp 1 0 0 2", erro, ocupacao, p, c); end
      push(8'h02);
      checks++; if (erro !== 1'b0 || topo_a !== 8'h02) begin errors++; $display("FAIL push_clears_erro got e%b %h exp 0 02", erro, topo_a); end
      executar(4'hE, c, p);
      checks++; if (erro !== 1'b1 || ocupacao !== 3'd1 || p !== 1'b0 || c !== 2) begin errors++; $display("FAIL invalid_op got e%b occ%0d p%b c%0d exp 1 1 0 2", erro, ocupacao, p, c); end
      push(8'h02);
      checks++; if (erro !== 1'b0 || ocupacao !== 3'd2) begin errors++; $display("FAIL recover got e%b occ%0d exp 0 2", erro, ocupacao); end
   endtask

   task automatic test_stack();
      int c;
      logic p;
      reset_dut();
      push(8'h01);
      push(8'hFF);
      executar(4'd0, c, p);
      push(8'h11);
      push(8'h22);
      executar(4'd7, c, p);
      checks++; if (topo_a !== 8'h11 || topo_b !== 8'h22 || p !== 1'b0) begin errors++; $display("FAIL swap got %h %h p%b exp 11 22 0", topo_a, topo_b, p); end
      executar(4'd6, c, p);
      checks++; if (ocupacao !== 3'd4 || topo_a !== 8'h11 || topo_b !== 8'h11) begin errors++; $display("FAIL dup got occ%0d %h %h exp 4 11 11", ocupacao, topo_a, topo_b); end
      executar(4'd6, c, p);
      checks++; if (erro !== 1'b1 || ocupacao !== 3'd4) begin errors++; $display("FAIL dup_full got e%b occ%0d exp 1 4", erro, ocupacao); end
      executar(4'd8, c, p);
      checks++; if (ocupacao !== 3'd3 || topo_a !== 8'h11 || topo_b !== 8'h22) begin errors++; $display("FAIL drop got occ%0d %h %h exp 3 11 22", ocupacao, topo_a, topo_b); end
      checks++; if (erro !== 1'b0 || zero !== 1'b1 || carry !== 1'b1 || resultado !== 8'h00) begin errors++; $display("FAIL stack_flags got e%b z%b c%b %h exp 0 1 1 00", erro, zero, carry, resultado); end
   endtask

   task automatic test_mul();
      int c;
      logic p;
      reset_dut();
      push(8'h0C);
      push(8'h0B);
      executar(4'd9, c, p);
`ifdef RPN_MULTIPLICADOR_EN
      checks++; if (resultado !== 8'h84 || overflow !== 1'b0 || p !== 1'b1 || ocupacao !== 3'd1) begin errors++; $display("FAIL mul got %h v%b p%b occ%0d exp 84 0 1 1", resultado, overflow, p, ocupacao); end
      checks++; if (c - 1 !== 9) begin errors++; $display("FAIL mul_latency got %0d exp 9", c - 1); end
      push(8'h20);
      executar(4'd9, c, p);
      checks++; if (resultado !== 8'h80 || overflow !== 1'b1 || zero !== 1'b0) begin errors++; $display("FAIL mul_ovf got %h v%b z%b exp 80 1 0", resultado, overflow, zero); end
`else
      checks++; if (erro !== 1'b1 || p !== 1'b0 || c !== 2 || ocupacao !== 3'd2) begin errors++; $display("FAIL mul_disabled got e%b p%b c%0d occ%0d exp 1 0 2 2", erro, p, c, ocupacao); end
`endif
   endtask

   task automatic test_reset_mid_op();
      int c;
      logic p;
      reset_dut();
      push(8'h01);
      push(8'h02);
      executar(4'd0, c, p);
      push(8'h0C);
      push(8'h0B);
      enviar(1'b1, 4'd9, 8'h00);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if ({topo_a, topo_b, resultado} !== 24'h0 || ocupacao !== 3'd0 || {zero, overflow, carry, erro, res_valido} !== 5'b0) begin errors++; $display("FAIL midop_reset got %h %h %h occ%0d flags %b exp zeros", topo_a, topo_b, resultado, ocupacao, {zero, overflow, carry, erro, res_valido}); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || resultado !== 8'h00 || res_valido !== 1'b0) begin errors++; $display("FAIL midop_after got rdy%b %h rv%b exp 1 00 0", in_ready, resultado, res_valido); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b1;
      in_eh_op = 1'b0;
      in_dado = 8'h10;
      @(negedge clk);
      in_dado = 8'h20;
      @(negedge clk);
      in_dado = 8'h30;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (ocupacao !== 3'd3 || topo_a !== 8'h30 || topo_b !== 8'h20) begin errors++; $display("FAIL b2b_push got occ%0d %h %h exp 3 30 20", ocupacao, topo_a, topo_b); end
      enviar(1'b1, 4'd0, 8'h00);
      in_valid = 1'b1;
      in_eh_op = 1'b0;
      in_dado = 8'h55;
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (ocupacao !== 3'd2 || topo_a !== 8'h50 || topo_b !== 8'h10) begin errors++; $display("FAIL busy_ignored got occ%0d %h %h exp 2 50 10", ocupacao, topo_a, topo_b); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_overflow();
      test_sub_logic();
      test_full();
      test_errors();
      test_stack();
      test_mul();
      test_reset_mid_op();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
